// File: rtl/spi_reg_bridge_if.sv
// Register-file side bus of the SPI register bridge: address, strobes and data.
interface spi_reg_bridge_if;
    logic [5:0] address;
    logic       write_en;
    logic [7:0] wr_data;
    logic       read_en;
    logic [7:0] rd_data;

    modport master (
        output address,
        output write_en,
        output wr_data,
        output read_en,
        input  rd_data
    );

    modport slave (
        input  address,
        input  write_en,
        input  wr_data,
        input  read_en,
        output rd_data
    );
endinterface

// File: rtl/spi_reg_bridge.sv
// SPI (mode 0) slave to register-file bridge. A frame is two bytes:
// {rw, rsvd, addr[5:0]} followed by write data (write) or read data
// shifted out on MISO (read). All SPI pins are oversampled by the system clock.
module spi_reg_bridge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               spi_clk,
    input  logic               spi_cs_n,
    input  logic               spi_mosi,
    output logic               spi_miso,
    output logic               busy,
    output logic               frame_error,
    spi_reg_bridge_if.master   reg_bus
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CMD    = 3'd1,
        RD_REQ = 3'd2,
        RD_CAP = 3'd3,
        DATA   = 3'd4,
        WR     = 3'd5,
        DONE   = 3'd6
    } state_t;

    logic [SYNC_STAGES-1:0] sclk_sync_r;
    logic [SYNC_STAGES-1:0] cs_sync_r;
    logic [SYNC_STAGES-1:0] mosi_sync_r;
    logic                   sclk_prev_r;
    logic                   cs_prev_r;

    logic sclk_s;
    logic cs_s;
    logic mosi_s;
    logic sclk_rise_s;
    logic sclk_fall_s;
    logic cs_rise_s;
    logic cs_fall_s;

    state_t     state_r;
    state_t     state_next_s;
    logic [4:0] bit_cnt_r;
    logic [7:0] rx_shift_r;
    logic [7:0] tx_shift_r;
    logic [7:0] rx_next_s;
    logic       tx_window_s;
    logic       rw_r;
    logic [5:0] address_r;
    logic [7:0] wr_data_r;
    logic       write_en_r;
    logic       read_en_r;
    logic       miso_r;
    logic       busy_r;
    logic       frame_error_r;

    assign sclk_s      = sclk_sync_r[SYNC_STAGES-1];
    assign cs_s        = cs_sync_r[SYNC_STAGES-1];
    assign mosi_s      = mosi_sync_r[SYNC_STAGES-1];
    assign sclk_rise_s = sclk_s & ~sclk_prev_r;
    assign sclk_fall_s = ~sclk_s & sclk_prev_r;
    assign cs_rise_s   = cs_s & ~cs_prev_r;
    assign cs_fall_s   = ~cs_s & cs_prev_r;
    assign rx_next_s   = {rx_shift_r[6:0], mosi_s};
    // Byte1 is shifted out on falls after the 8th..15th rising edge.
    assign tx_window_s = (bit_cnt_r >= 5'd8) && (bit_cnt_r <= 5'd15);

    // Synchronize the asynchronous SPI pins and keep last values for edge detection.
    // Reset to 0 so a chip select already low at release is not seen as a frame start.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sclk_sync_r <= '0;
            cs_sync_r   <= '0;
            mosi_sync_r <= '0;
            sclk_prev_r <= 1'b0;
            cs_prev_r   <= 1'b0;
        end else begin
            sclk_sync_r <= {sclk_sync_r[SYNC_STAGES-2:0], spi_clk};
            cs_sync_r   <= {cs_sync_r[SYNC_STAGES-2:0], spi_cs_n};
            mosi_sync_r <= {mosi_sync_r[SYNC_STAGES-2:0], spi_mosi};
            sclk_prev_r <= sclk_s;
            cs_prev_r   <= cs_s;
        end
    end

    // State register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic; chip select going high aborts any frame.
    always_comb begin
        state_next_s = state_r;
        if ((state_r != IDLE) && cs_s) begin
            state_next_s = IDLE;
        end else begin
            case (state_r)
                IDLE: begin
                    if (cs_fall_s) begin
                        state_next_s = CMD;
                    end else begin
                        state_next_s = IDLE;
                    end
                end
                CMD: begin
                    if (sclk_rise_s && (bit_cnt_r == 5'd7)) begin
                        state_next_s = rx_next_s[7] ? RD_REQ : DATA;
                    end else begin
                        state_next_s = CMD;
                    end
                end
                RD_REQ: state_next_s = RD_CAP;
                RD_CAP: state_next_s = DATA;
                DATA: begin
                    if (sclk_rise_s && (bit_cnt_r == 5'd15)) begin
                        state_next_s = rw_r ? DONE : WR;
                    end else begin
                        state_next_s = DATA;
                    end
                end
                WR:      state_next_s = DONE;
                DONE:    state_next_s = DONE;
                default: state_next_s = IDLE;
            endcase
        end
    end

    // Bit counter and shift registers; cleared whenever no frame is active.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            bit_cnt_r  <= 5'd0;
            rx_shift_r <= 8'h00;
            tx_shift_r <= 8'h00;
        end else if (state_r == IDLE) begin
            bit_cnt_r  <= 5'd0;
            rx_shift_r <= 8'h00;
            tx_shift_r <= 8'h00;
        end else begin
            if (sclk_rise_s && (bit_cnt_r != 5'd16)) begin
                bit_cnt_r <= bit_cnt_r + 5'd1;
            end
            if (sclk_rise_s) begin
                rx_shift_r <= rx_next_s;
            end
            if (state_r == RD_CAP) begin
                tx_shift_r <= reg_bus.rd_data;
            end else if ((state_r == DATA) && sclk_fall_s && tx_window_s) begin
                tx_shift_r <= {tx_shift_r[6:0], 1'b0};
            end
        end
    end

    // Address/rw latch at end of byte0, write data latch at end of byte1; both hold between frames.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            address_r <= 6'd0;
            rw_r      <= 1'b0;
            wr_data_r <= 8'h00;
        end else begin
            if ((state_r == CMD) && ((state_next_s == RD_REQ) || (state_next_s == DATA))) begin
                address_r <= rx_next_s[5:0];
                rw_r      <= rx_next_s[7];
            end
            if ((state_r == DATA) && (state_next_s == WR)) begin
                wr_data_r <= rx_next_s;
            end
        end
    end

    // Registered strobes and status, aligned with the state they belong to.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            write_en_r    <= 1'b0;
            read_en_r     <= 1'b0;
            busy_r        <= 1'b0;
            frame_error_r <= 1'b0;
        end else begin
            write_en_r    <= (state_next_s == WR);
            read_en_r     <= (state_next_s == RD_REQ);
            busy_r        <= (state_next_s != IDLE);
            frame_error_r <= cs_rise_s && (state_r != IDLE) &&
                             (bit_cnt_r >= 5'd1) && (bit_cnt_r <= 5'd15);
        end
    end

    // MISO driver: tx[7] on falls inside the byte1 window, 0 everywhere else.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            miso_r <= 1'b0;
        end else if ((state_r == DATA) && (state_next_s == DATA) && sclk_fall_s) begin
            miso_r <= tx_window_s ? tx_shift_r[7] : 1'b0;
        end else if (state_next_s != DATA) begin
            miso_r <= 1'b0;
        end else begin
            miso_r <= miso_r;
        end
    end

    assign reg_bus.address  = address_r;
    assign reg_bus.write_en = write_en_r;
    assign reg_bus.wr_data  = wr_data_r;
    assign reg_bus.read_en  = read_en_r;
    assign spi_miso         = miso_r;
    assign busy             = busy_r;
    assign frame_error      = frame_error_r;

endmodule

// File: tb/tb_spi_reg_bridge.sv
// Scoreboard bench for spi_reg_bridge: stimulus pushes expected register-bus
// events, a monitor pops and compares them as strobes appear.
module tb_spi_reg_bridge;
    localparam int HALF = 50;   // half SPI period in ns (SPI period = 10 clocks)
    localparam int GAP  = 100;  // chip select high time between frames

    logic clock    = 1'b0;
    logic reset_n  = 1'b0;
    logic spi_clk  = 1'b0;
    logic spi_cs_n = 1'b1;
    logic spi_mosi = 1'b0;
    logic spi_miso;
    logic busy;
    logic frame_error;

    spi_reg_bridge_if bus ();

    spi_reg_bridge #(.SYNC_STAGES(2)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .spi_clk     (spi_clk),
        .spi_cs_n    (spi_cs_n),
        .spi_mosi    (spi_mosi),
        .spi_miso    (spi_miso),
        .busy        (busy),
        .frame_error (frame_error),
        .reg_bus     (bus)
    );

    always #5 clock = ~clock;

    int          checks = 0;
    int          errors = 0;
    logic [15:0] exp_q[$];      // {kind[1:0], addr[5:0], data[7:0]}; kind 0 write, 1 read, 2 frame_error
    time         rise16_t = 0;
    logic [7:0]  mem [0:63];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Simple register file: read data appears on the clock after read_en.
    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 64; i++) mem[i] <= 8'h00;
            mem[6'h0F] <= 8'h3C;
            mem[6'h3F] <= 8'h81;
            bus.rd_data <= 8'h00;
        end else begin
            if (bus.write_en) mem[bus.address] <= bus.wr_data;
            if (bus.read_en) bus.rd_data <= mem[bus.address];
        end
    end

    task automatic take_event(input logic [15:0] act);
        logic [15:0] e;
        if (exp_q.size() == 0) begin
            check("unexpected_event", {16'd0, act}, 32'hFFFFFFFF);
        end else begin
            e = exp_q.pop_front();
            check("bus_event", {16'd0, act}, {16'd0, e});
        end
    endtask

    // Monitor: compare every strobe against the head of the expected queue.
    always @(negedge clock) begin
        if (reset_n) begin
            if (bus.write_en && bus.read_en) check("strobe_exclusive", 32'd1, 32'd0);
            if (bus.write_en) begin
                take_event({2'd0, bus.address, bus.wr_data});
                check("wr_latency", (($time - rise16_t) <= 40) ? 32'd1 : 32'd0, 32'd1);
            end
            if (bus.read_en) take_event({2'd1, bus.address, 8'h00});
            if (frame_error) take_event({2'd2, 6'd0, 8'h00});
        end
    end

    // One SPI frame of nbits, MSB first from data[23]; optional reset pulse before bit rst_bit.
    task automatic frame(input logic [23:0] data, input int nbits, input int rst_bit,
                         output logic [7:0] m0, output logic [7:0] m1);
        m0 = 8'h00;
        m1 = 8'h00;
        spi_cs_n = 1'b0;
        for (int i = 0; i < nbits; i++) begin
            spi_mosi = data[23-i];
            #HALF;
            if (i == 0) check("busy_in_frame", {31'd0, busy}, 32'd1);
            if (i == rst_bit) begin
                reset_n = 1'b0;
                #1;
                check("rst_address", {26'd0, bus.address}, 32'd0);
                check("rst_wr_data", {24'd0, bus.wr_data}, 32'd0);
                check("rst_strobes", {30'd0, bus.write_en, bus.read_en}, 32'd0);
                check("rst_miso_busy_ferr", {29'd0, spi_miso, busy, frame_error}, 32'd0);
                #9;
                reset_n = 1'b1;
            end
            if (i < 8) m0 = {m0[6:0], spi_miso};
            else if (i < 16) m1 = {m1[6:0], spi_miso};
            spi_clk = 1'b1;
            if (i == 15) rise16_t = $time;
            #HALF;
            spi_clk = 1'b0;
        end
        #HALF;
        spi_cs_n = 1'b1;
        #GAP;
        check("busy_after_frame", {31'd0, busy}, 32'd0);
    endtask

    logic [7:0] m0;
    logic [7:0] m1;

    initial begin
        #12;
        check("reset_address", {26'd0, bus.address}, 32'd0);
        check("reset_wr_data", {24'd0, bus.wr_data}, 32'd0);
        check("reset_strobes", {30'd0, bus.write_en, bus.read_en}, 32'd0);
        check("reset_miso_busy_ferr", {29'd0, spi_miso, busy, frame_error}, 32'd0);
        @(negedge clock);
        reset_n = 1'b1;
        repeat (5) @(negedge clock);

        // Write 0xA5 to 0x04.
        exp_q.push_back({2'd0, 6'h04, 8'hA5});
        frame({8'h04, 8'hA5, 8'h00}, 16, -1, m0, m1);
        check("wr_miso", {16'd0, m0, m1}, 32'h0000);

        // Read 0x0F returns 0x3C on byte1.
        exp_q.push_back({2'd1, 6'h0F, 8'h00});
        frame({8'h8F, 8'h00, 8'h00}, 16, -1, m0, m1);
        check("rd_miso_byte0", {24'd0, m0}, 32'h00);
        check("rd_miso_byte1", {24'd0, m1}, 32'h3C);

        // Write aborted after 11 bits, then a good write.
        exp_q.push_back({2'd2, 6'd0, 8'h00});
        frame({8'h02, 8'hFF, 8'h00}, 11, -1, m0, m1);
        exp_q.push_back({2'd0, 6'h06, 8'h11});
        frame({8'h06, 8'h11, 8'h00}, 16, -1, m0, m1);

        // 24-bit frame: third byte ignored.
        exp_q.push_back({2'd0, 6'h01, 8'hFF});
        frame({8'h01, 8'hFF, 8'h55}, 24, -1, m0, m1);
        check("long_miso", {16'd0, m0, m1}, 32'h0000);

        // Reset during bit 12 of a write: no strobe at all.
        frame({8'h22, 8'h33, 8'h00}, 16, 11, m0, m1);

        // Back-to-back write then read-back with one SPI period gap.
        exp_q.push_back({2'd0, 6'h10, 8'h77});
        frame({8'h10, 8'h77, 8'h00}, 16, -1, m0, m1);
        exp_q.push_back({2'd1, 6'h10, 8'h00});
        frame({8'h90, 8'h00, 8'h00}, 16, -1, m0, m1);
        check("b2b_rd_miso", {16'd0, m0, m1}, 32'h0077);

        // Top address with rsvd bit set.
        exp_q.push_back({2'd1, 6'h3F, 8'h00});
        frame({8'hFF, 8'h00, 8'h00}, 16, -1, m0, m1);
        check("top_rd_miso", {16'd0, m0, m1}, 32'h0081);

        repeat (20) @(negedge clock);
        check("queue_empty", exp_q.size(), 32'd0);
        check("hold_address", {26'd0, bus.address}, 32'h3F);
        check("hold_wr_data", {24'd0, bus.wr_data}, 32'h77);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
